// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and defaults for the two-requester APB master.
package apb_master_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} apb_mst_state_e;

    localparam int unsigned DEF_NUM_SLV = 4;
    localparam logic [15:0] DEF_BASE_HI = 16'h1000;
    localparam int unsigned DEF_TIMEOUT = 16;
    localparam int unsigned SEL_LSB     = 12;

    // An access is valid when the upper half matches the window and the slave index exists.
    function automatic logic decode_ok(input logic [31:0] addr, input logic [15:0] base_hi,
                                       input int unsigned num_slv);
        return (addr[31:16] == base_hi) && ({28'h0, addr[SEL_LSB +: 4]} < num_slv);
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signal bundle for apb_master_arbiter.
interface apb_master_arbiter_if #(
    parameter int unsigned NUM_SLV = apb_master_arbiter_pkg::DEF_NUM_SLV
);
    logic [1:0]                m_req;
    logic [1:0]                m_write;
    logic [1:0][31:0]          m_addr;
    logic [1:0][31:0]          m_wdata;
    logic [1:0][31:0]          m_rdata;
    logic [1:0]                m_done;
    logic [1:0]                m_err;
    logic [31:0]               PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PENABLE;
    logic [NUM_SLV-1:0]        PSEL;
    logic [NUM_SLV-1:0][31:0]  PRDATA;
    logic [NUM_SLV-1:0]        PREADY;

    modport master (
        input  m_req, m_write, m_addr, m_wdata, PRDATA, PREADY,
        output m_rdata, m_done, m_err, PADDR, PWDATA, PWRITE, PENABLE, PSEL
    );

    modport slave (
        output m_req, m_write, m_addr, m_wdata, PRDATA, PREADY,
        input  m_rdata, m_done, m_err, PADDR, PWDATA, PWRITE, PENABLE, PSEL
    );
endinterface

// File: rtl/apb_master_arbiter_rr.sv
// Two-way round-robin arbiter; last_grant resets to 1 so requester 0 wins the first tie.
module apb_master_arbiter_rr (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [1:0] eligible,
    input  logic       gnt_stb,
    output logic       gnt_idx,
    output logic       valid
);
    logic last_grant;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            last_grant <= 1'b1;
        end else if (gnt_stb) begin
            last_grant <= gnt_idx;
        end
    end

    always_comb begin
        valid   = |eligible;
        gnt_idx = (eligible == 2'b11) ? ~last_grant : eligible[1];
    end
endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters: round-robin grant, one-hot decode, SETUP/ACCESS sequencing.
module apb_master_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SLV = DEF_NUM_SLV,
    parameter logic [15:0] BASE_HI = DEF_BASE_HI,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_master_arbiter_if.master bus
);
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    apb_mst_state_e     state_q, state_n;
    logic               gidx_q, gidx_n;
    logic [CW-1:0]      wcnt_q, wcnt_n;
    logic [31:0]        paddr_q, paddr_n, pwdata_q, pwdata_n;
    logic               pwrite_q, pwrite_n, penable_q, penable_n;
    logic [NUM_SLV-1:0] psel_q, psel_n;
    logic [1:0][31:0]   m_rdata_q, m_rdata_n;
    logic [1:0]         m_done_q, m_done_n, m_err_q, m_err_n;

    logic               gnt_stb, arb_idx, arb_valid, sel_ready;
    logic [31:0]        req_addr, rd_sel;

    apb_master_arbiter_rr u_rr (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .eligible (bus.m_req & ~m_done_q),
        .gnt_stb  (gnt_stb),
        .gnt_idx  (arb_idx),
        .valid    (arb_valid)
    );

    assign req_addr  = bus.m_addr[arb_idx];
    // PSEL is one-hot, so masking with it picks the selected slave's lane only.
    assign sel_ready = |(bus.PREADY & psel_q);

    always_comb begin
        rd_sel = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (psel_q[i]) rd_sel |= bus.PRDATA[i];
        end
    end

    always_comb begin
        state_n   = state_q;
        gidx_n    = gidx_q;
        wcnt_n    = wcnt_q;
        paddr_n   = paddr_q;
        pwdata_n  = pwdata_q;
        pwrite_n  = pwrite_q;
        penable_n = penable_q;
        psel_n    = psel_q;
        m_rdata_n = m_rdata_q;
        m_done_n  = '0;
        m_err_n   = '0;
        gnt_stb   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_stb = 1'b1;
                    gidx_n  = arb_idx;
                    if (decode_ok(req_addr, BASE_HI, NUM_SLV)) begin
                        paddr_n  = req_addr;
                        pwdata_n = bus.m_wdata[arb_idx];
                        pwrite_n = bus.m_write[arb_idx];
                        psel_n   = NUM_SLV'(1) << req_addr[SEL_LSB +: 4];
                        state_n  = SETUP;
                    end else begin
                        state_n  = ERR;
                    end
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                wcnt_n    = '0;
                state_n   = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    psel_n           = '0;
                    penable_n        = 1'b0;
                    m_done_n[gidx_q] = 1'b1;
                    if (!pwrite_q) m_rdata_n[gidx_q] = rd_sel;
                    state_n          = IDLE;
                end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                    psel_n            = '0;
                    penable_n         = 1'b0;
                    m_done_n[gidx_q]  = 1'b1;
                    m_err_n[gidx_q]   = 1'b1;
                    m_rdata_n[gidx_q] = '0;
                    state_n           = IDLE;
                end else begin
                    wcnt_n = wcnt_q + 1'b1;
                end
            end
            ERR: begin
                m_done_n[gidx_q]  = 1'b1;
                m_err_n[gidx_q]   = 1'b1;
                m_rdata_n[gidx_q] = '0;
                state_n           = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            gidx_q    <= 1'b0;
            wcnt_q    <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            psel_q    <= '0;
            m_rdata_q <= '0;
            m_done_q  <= '0;
            m_err_q   <= '0;
        end else begin
            state_q   <= state_n;
            gidx_q    <= gidx_n;
            wcnt_q    <= wcnt_n;
            paddr_q   <= paddr_n;
            pwdata_q  <= pwdata_n;
            pwrite_q  <= pwrite_n;
            penable_q <= penable_n;
            psel_q    <= psel_n;
            m_rdata_q <= m_rdata_n;
            m_done_q  <= m_done_n;
            m_err_q   <= m_err_n;
        end
    end

    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PENABLE = penable_q;
    assign bus.PSEL    = psel_q;
    assign bus.m_rdata = m_rdata_q;
    assign bus.m_done  = m_done_q;
    assign bus.m_err   = m_err_q;
endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Single APB master that lets two requesters share the peripheral bus.
- Requesters are, for example, CPU-side load/store and a DMA/test sequencer.
- Arbitrates round-robin, decodes the address into one-hot PSEL, and sequences APB SETUP/ACCESS phases against the GPIO and sibling slaves.
- Returns read data, a done pulse and an error flag (decode miss or timeout) to the granted requester.

Parameters:
- NUM_SLV, 4: number of APB slaves and PSEL/PRDATA/PREADY lanes; max 16.
- BASE_HI, 16'h1000: required value of addr[31:16] for a valid access.
- TIMEOUT, 16: ACCESS cycles without PREADY before the transfer aborts with error; must be ≥ 2.

Ports:
- PCLK  in  1  clock
- PRESET  in  1  asynchronous active-high reset
- m_req  in  2  per-requester request; held until that requester's m_done
- m_write  in  2  per-requester write (1) / read (0)
- m_addr  in  2x32  per-requester byte address
- m_wdata  in  2x32  per-requester write data
- m_rdata  out  2x32  per-requester read data, valid when m_done=1
- m_done  out  2  one-cycle completion pulse
- m_err  out  2  high with m_done on decode miss or timeout
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PENABLE  out  1  APB access phase
- PSEL  out  NUM_SLV  one-hot slave select
- PRDATA  in  NUM_SLVx32  per-slave read data
- PREADY  in  NUM_SLV  per-slave ready

Behaviour:
- Clock is PCLK; reset is PRESET, asynchronous, active-high.
- All outputs are registered. Reset forces: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, m_done=0, m_err=0, m_rdata=0, FSM=IDLE, last_grant=1 (requester 0 wins the first tie). This applies mid-transfer too.
- FSM has four states: IDLE, SETUP, ACCESS, ERR.
- IDLE:
  - Eligible requesters are those with m_req=1 and m_done=0 in the current cycle. A requester drops m_req on the edge where it samples m_done.
  - One eligible requester: grant it. Both eligible: grant !last_grant. On grant, update last_grant and latch addr/wdata/write.
  - Decode: sel = addr[15:12].
  - If addr[31:16]==BASE_HI and sel<NUM_SLV: drive PADDR/PWDATA/PWRITE, set PSEL[sel]=1, go to SETUP.
  - Otherwise go to ERR with no APB activity.
- SETUP: lasts exactly one cycle. PSEL held, PENABLE=0. Set PENABLE=1 and go to ACCESS.
- ACCESS:
  - Hold all APB outputs. Only PREADY[sel] is observed; PREADY of other slaves is ignored.
  - A wait counter starts at 0 on ACCESS entry and increments each cycle PREADY[sel]=0.
  - PREADY[sel]=1: clear PSEL/PENABLE; m_done[g]<=1; on a read, m_rdata[g]<=PRDATA[sel] (writes leave m_rdata unchanged); go to IDLE.
  - Counter reaches TIMEOUT-1 with PREADY still 0: clear PSEL/PENABLE; m_done[g]<=1, m_err[g]<=1, m_rdata[g]<=0; go to IDLE.
- ERR: m_done[g]<=1, m_err[g]<=1, m_rdata[g]<=0; go to IDLE.
- m_done and m_err are high for exactly one cycle.
- Transfers are never back-to-back. IDLE always separates them; minimum 3 cycles from grant to m_done.
- A GPIO slave registers PREADY one cycle after PSEL&PENABLE, so a GPIO access has 2 ACCESS cycles: done appears 4 edges after grant.
- m_req dropping mid-transfer is ignored; the transfer completes and m_done still pulses.
- The non-granted requester's outputs stay 0 / hold.

Decomposition:
- apb_pkg holds:
  - typedef enum {IDLE, SETUP, ACCESS, ERR} apb_mst_state_e
  - default NUM_SLV, BASE_HI, TIMEOUT
  - localparam SEL_LSB=12
- One sub-module, apb_rr_arbiter: 2-way round-robin with inputs eligible[1:0] and a grant strobe. It outputs gnt_idx and valid, and owns last_grant.

Test Plan:
- Write via m0: addr 0x1000_0008, wdata 0x0000_00A5, GPIO on slave 0 → PSEL=0001, PADDR=0x1000_0008, PWRITE=1. SETUP 1 cycle, ACCESS 2 cycles. m_done[0] pulses, m_err[0]=0.
- Read via m1: addr 0x1000_0004, slave 0 PRDATA=0x0000_3C3C → m_rdata[1]=0x0000_3C3C with m_done[1]. No PSEL to other slaves.
- m0 and m1 request the same cycle after reset → grant order m0, m1, m0, m1 over four transfers, each separated by IDLE.
- Decode misses: addr 0x2000_0000 or 0x1000_5000 with NUM_SLV=4 → no PSEL ever asserted; m_done=1 and m_err=1 two edges after grant; m_rdata=0.
- Slave 2 holds PREADY=0 → PSEL[2]/PENABLE drop after 16 ACCESS cycles; m_done=1, m_err=1. The next transfer to slave 0 succeeds normally.
- PRESET pulsed during ACCESS → PSEL/PENABLE/m_done go 0 immediately. After release, m0 wins the first tie.
